stage_5: RTL

//  Writeback stage of the 5-stage RISC-V core. Accepts retired ops from the memory stage, waits for

---
 rtl/stage_5_pkg.sv | 31 +++
 rtl/stage_5_load_aligner.sv | 42 ++++
 rtl/stage_5.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/stage_5_pkg.sv
// Shared encodings and types for the writeback stage: RV32 opcodes, load func_3 codes,
// FSM states and the load descriptor held while waiting on memory.
package stage_5_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_MEM,
        ST_COMMIT
    } state_t;

    typedef struct packed {
        logic [4:0] rd_num;
        logic [2:0] func_3;
        logic [1:0] lane;
    } ld_op_t;

endpackage

// File: rtl/stage_5_load_aligner.sv
// Combinational load alignment: picks the byte/half lane out of a word-aligned read,
// sign/zero-extends it, and flags misaligned half/word accesses.
module stage_5_load_aligner
    import stage_5_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_word,
    input  logic [1:0]      i_lane,
    input  logic [2:0]      i_func_3,
    output logic [XLEN-1:0] o_value,
    output logic            o_misalign
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v     = 8'(i_word >> {i_lane, 3'b000});
        half_v     = i_lane[1] ? i_word[31:16] : i_word[15:0];
        o_value    = '0;
        o_misalign = 1'b0;
        case (i_func_3)
            F3_LB:  o_value = {{(XLEN-8){byte_v[7]}}, byte_v};
            F3_LBU: o_value = {{(XLEN-8){1'b0}}, byte_v};
            F3_LH: begin
                o_value    = {{(XLEN-16){half_v[15]}}, half_v};
                o_misalign = i_lane[0];
            end
            F3_LHU: begin
                o_value    = {{(XLEN-16){1'b0}}, half_v};
                o_misalign = i_lane[0];
            end
            F3_LW: begin
                o_value    = i_word;
                o_misalign = |i_lane;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/stage_5.sv
// Writeback stage: latches retired ops, waits for load data with a bounded timeout,
// drives the register-file write port and counts committed ops.
module stage_5
    import stage_5_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [6:0]       i_opcode,
    input  logic [2:0]       i_func_3,
    input  logic [4:0]       i_rd_num,
    input  logic [XLEN-1:0]  i_alu_res,
    input  logic [XLEN-1:0]  i_pc,
    input  logic [XLEN-1:0]  i_mem_data,
    input  logic             i_mem_valid,
    output logic             o_stall,
    output logic             o_reg_op,
    output logic [XLEN-1:0]  o_w_rd,
    output logic [4:0]       o_w_rd_num,
    output logic             o_misalign,
    output logic             o_timeout,
    output logic [CNT_W-1:0] o_retired
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    state_t           state_q, state_d;
    ld_op_t           ld_q, ld_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             reg_op_q, reg_op_d;
    logic [XLEN-1:0]  w_rd_q, w_rd_d;
    logic [4:0]       w_rd_num_q, w_rd_num_d;
    logic             misalign_q, misalign_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic             accept, commit, wr_en;
    logic [XLEN-1:0]  wr_val;
    logic [4:0]       wr_num;
    logic [XLEN-1:0]  al_value;
    logic             al_misalign;
    logic             waiting;

    assign waiting = (state_q == ST_WAIT_MEM);
    assign o_stall = waiting;
    assign accept  = i_valid && !waiting;

    // While waiting, the aligner works on the latched lane; otherwise it checks the incoming op.
    stage_5_load_aligner #(.XLEN(XLEN)) u_aligner (
        .i_word     (i_mem_data),
        .i_lane     (waiting ? ld_q.lane   : i_alu_res[1:0]),
        .i_func_3   (waiting ? ld_q.func_3 : i_func_3),
        .o_value    (al_value),
        .o_misalign (al_misalign)
    );

    always_comb begin
        state_d    = state_q;
        ld_d       = ld_q;
        tmo_d      = tmo_q;
        reg_op_d   = 1'b0;
        w_rd_d     = w_rd_q;
        w_rd_num_d = w_rd_num_q;
        misalign_d = 1'b0;
        timeout_d  = 1'b0;
        retired_d  = retired_q;
        commit     = 1'b0;
        wr_en      = 1'b0;
        wr_val     = '0;
        wr_num     = '0;
        case (state_q)
            ST_WAIT_MEM: begin
                if (i_mem_valid) begin
                    commit  = 1'b1;
                    wr_en   = 1'b1;
                    wr_val  = al_value;
                    wr_num  = ld_q.rd_num;
                    state_d = ST_COMMIT;
                end else if (tmo_q == TW'(MEM_TIMEOUT)) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                if (accept) begin
                    state_d = ST_COMMIT;
                    commit  = 1'b1;
                    wr_num  = i_rd_num;
                    case (i_opcode)
                        OPC_LOAD: begin
                            if (al_misalign) begin
                                misalign_d = 1'b1;
                            end else begin
                                commit  = 1'b0;
                                state_d = ST_WAIT_MEM;
                                ld_d    = '{rd_num: i_rd_num, func_3: i_func_3, lane: i_alu_res[1:0]};
                                tmo_d   = TW'(1);
                            end
                        end
                        OPC_LUI, OPC_AUIPC, OPC_OP, OPC_OP_IMM: begin
                            wr_en  = 1'b1;
                            wr_val = i_alu_res;
                        end
                        OPC_JAL, OPC_JALR: begin
                            wr_en  = 1'b1;
                            wr_val = i_pc + XLEN'(4);
                        end
                        default: ;
                    endcase
                end
            end
        endcase
        if (commit) retired_d = retired_q + CNT_W'(1);
        // x0 is never written; the port keeps its previous value.
        if (wr_en && (wr_num != 5'd0)) begin
            reg_op_d   = 1'b1;
            w_rd_d     = wr_val;
            w_rd_num_d = wr_num;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            ld_q       <= '0;
            tmo_q      <= '0;
            reg_op_q   <= 1'b0;
            w_rd_q     <= '0;
            w_rd_num_q <= '0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            ld_q       <= ld_d;
            tmo_q      <= tmo_d;
            reg_op_q   <= reg_op_d;
            w_rd_q     <= w_rd_d;
            w_rd_num_q <= w_rd_num_d;
            misalign_q <= misalign_d;
            timeout_q  <= timeout_d;
            retired_q  <= retired_d;
        end
    end

    assign o_reg_op   = reg_op_q;
    assign o_w_rd     = w_rd_q;
    assign o_w_rd_num = w_rd_num_q;
    assign o_misalign = misalign_q;
    assign o_timeout  = timeout_q;
    assign o_retired  = retired_q;

endmodule
